// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: register offsets,
// STATUS/CTRL bit positions and the receiver FSM state encoding.
package uart_pkg;

  localparam logic [3:0] ADDR_RXDATA = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h4;
  localparam logic [3:0] ADDR_CTRL   = 4'h8;

  localparam int unsigned STAT_NOT_EMPTY = 0;
  localparam int unsigned STAT_FULL      = 1;
  localparam int unsigned STAT_OVERRUN   = 2;
  localparam int unsigned STAT_FRAME_ERR = 3;
  localparam int unsigned STAT_FILL_LSB  = 4;

  localparam int unsigned CTRL_IRQ_EN   = 0;
  localparam int unsigned CTRL_CLR_OVR  = 1;
  localparam int unsigned CTRL_CLR_FERR = 2;
  localparam int unsigned CTRL_FLUSH    = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/rx_fifo.sv
// Synchronous receive FIFO with zero-latency head output.
// Push while full is accepted only when a pop happens the same cycle;
// flush takes priority over both push and pop.
module rx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage write; the array itself needs no reset.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_rx_mmio.sv
// Memory-mapped 8N1 UART receiver: input synchroniser, oversampling
// tick divider, receive FSM, RX FIFO and the RXDATA/STATUS/CTRL registers.
module uart_rx_mmio
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  uart_rx,
  input  logic [3:0]            addr,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rx_irq
);

  localparam int unsigned DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned T_W   = $clog2(OVERSAMPLE);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [T_W-1:0]   T_HALF   = T_W'(OVERSAMPLE / 2 - 1);
  localparam logic [T_W-1:0]   T_LAST   = T_W'(OVERSAMPLE - 1);

  logic             rx_meta;
  logic             rx_s;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  rx_state_t        state, state_next;
  logic [T_W-1:0]   t, t_next;
  logic [2:0]       bit_idx, bit_next;
  logic [7:0]       shift, shift_next;
  logic             push_req;
  logic             ferr_set;

  logic             ctrl_wr;
  logic             flush;
  logic             rx_pop;
  logic             fifo_push;
  logic             ovr_set;
  logic             overrun;
  logic             frame_err;
  logic             irq_en;

  logic [7:0]       fifo_dout;
  logic             fifo_empty;
  logic             fifo_full;
  logic [CNT_W-1:0] fifo_count;
  logic [31:0]      cnt_ext;
  logic [3:0]       fill;
  logic             unused_wdata;

  // Two-flop synchroniser; idles high so reset does not look like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
    end
  end

  assign tick = (div_cnt == DIV_LAST);

  // Oversample divider: held at zero in IDLE so every frame starts phase-aligned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (state == IDLE || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Receiver state register and shift datapath.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      t       <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_next;
      t       <= t_next;
      bit_idx <= bit_next;
      shift   <= shift_next;
    end
  end

  // Next-state logic: half-bit start validation, mid-bit data/stop sampling.
  always_comb begin
    state_next = state;
    t_next     = t;
    bit_next   = bit_idx;
    shift_next = shift;
    push_req   = 1'b0;
    ferr_set   = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          t_next     = '0;
        end
      end
      START: begin
        if (tick) begin
          if (t == T_HALF) begin
            t_next = '0;
            if (!rx_s) begin
              state_next = DATA;
              bit_next   = '0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            t_next = t + T_W'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (t == T_LAST) begin
            t_next              = '0;
            shift_next[bit_idx] = rx_s;
            if (bit_idx == 3'd7) state_next = STOP;
            else                 bit_next   = bit_idx + 3'd1;
          end else begin
            t_next = t + T_W'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (t == T_LAST) begin
            t_next     = '0;
            state_next = IDLE;
            if (rx_s) push_req = 1'b1;
            else      ferr_set = 1'b1;
          end else begin
            t_next = t + T_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign ctrl_wr   = mem_write && (addr == ADDR_CTRL);
  assign flush     = ctrl_wr && wdata[CTRL_FLUSH];
  assign rx_pop    = mem_read && (addr == ADDR_RXDATA) && !fifo_empty;
  // A full FIFO still takes the byte when the same cycle pops; a flush drops it silently.
  assign fifo_push = push_req && (!fifo_full || rx_pop);
  assign ovr_set   = push_req && fifo_full && !rx_pop && !flush;

  rx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (rx_pop),
    .flush (flush),
    .din   (shift_next),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  // Sticky error flags (set beats W1C clear) and the stored interrupt enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      irq_en    <= 1'b0;
    end else begin
      if (ovr_set)                              overrun <= 1'b1;
      else if (ctrl_wr && wdata[CTRL_CLR_OVR])  overrun <= 1'b0;
      if (ferr_set)                             frame_err <= 1'b1;
      else if (ctrl_wr && wdata[CTRL_CLR_FERR]) frame_err <= 1'b0;
      if (ctrl_wr)                              irq_en <= wdata[CTRL_IRQ_EN];
    end
  end

  assign cnt_ext      = 32'(fifo_count);
  assign fill         = (cnt_ext > 32'd15) ? 4'hF : cnt_ext[3:0];
  assign rx_irq       = irq_en && !fifo_empty;
  assign unused_wdata = ^wdata[DATA_WIDTH-1:4];

  // Zero-latency register read mux.
  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_RXDATA: begin
        if (!fifo_empty) rdata[7:0] = fifo_dout;
      end
      ADDR_STATUS: begin
        rdata[STAT_NOT_EMPTY]       = !fifo_empty;
        rdata[STAT_FULL]            = fifo_full;
        rdata[STAT_OVERRUN]         = overrun;
        rdata[STAT_FRAME_ERR]       = frame_err;
        rdata[STAT_FILL_LSB +: 4]   = fill;
      end
      ADDR_CTRL: begin
        rdata[CTRL_IRQ_EN] = irq_en;
      end
      default: rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Self-checking bench for uart_rx_mmio: table-driven single frames,
// hand-written corner sequences and randomized frames against a queue model.
`timescale 1ns/1ps
module tb_uart_rx_mmio;
  import uart_pkg::*;

  localparam int unsigned BIT_CLK = 432;
  localparam int unsigned DEPTH   = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        uart_rx;
  logic [3:0]  addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rx_irq;

  int checks = 0;
  int errors = 0;

  // Behavioural model: received bytes, sticky flags, interrupt enable.
  logic [7:0] mq[$];
  logic       m_ovr;
  logic       m_ferr;
  logic       m_irq_en;

  uart_rx_mmio #(
    .CLK_FREQ   (50_000_000),
    .BAUD       (115200),
    .OVERSAMPLE (16),
    .FIFO_DEPTH (DEPTH),
    .DATA_WIDTH (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .uart_rx   (uart_rx),
    .addr      (addr),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .wdata     (wdata),
    .rdata     (rdata),
    .rx_irq    (rx_irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h want=0x%08h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovr    = 1'b0;
    m_ferr   = 1'b0;
    m_irq_en = 1'b0;
  endtask

  function automatic logic [31:0] model_reg(input logic [3:0] a);
    logic [31:0] r;
    int n;
    r = '0;
    n = mq.size();
    if (a == ADDR_RXDATA) begin
      if (n > 0) r[7:0] = mq[0];
    end else if (a == ADDR_STATUS) begin
      r[0]   = (n != 0);
      r[1]   = (n == DEPTH);
      r[2]   = m_ovr;
      r[3]   = m_ferr;
      r[7:4] = (n > 15) ? 4'hF : 4'(n);
    end else if (a == ADDR_CTRL) begin
      r[0] = m_irq_en;
    end
    return r;
  endfunction

  function automatic logic [31:0] model_irq();
    return {31'b0, m_irq_en && (mq.size() > 0)};
  endfunction

  task automatic drive_bit(input logic b);
    uart_rx = b;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic idle(input int n);
    uart_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // One 8N1 frame, LSB first; the model records its outcome afterwards.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    @(negedge clk);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
    uart_rx = 1'b1;
    if (stop) begin
      if (mq.size() < DEPTH) mq.push_back(d);
      else                   m_ovr = 1'b1;
    end else begin
      m_ferr = 1'b1;
    end
  endtask

  task automatic read_check(input string name, input logic [3:0] a, output logic [31:0] got);
    logic [31:0] exp;
    exp = model_reg(a);
    @(negedge clk);
    addr     = a;
    mem_read = 1'b1;
    #1 got = rdata;
    check(name, got, exp);
    if (a == ADDR_RXDATA && mq.size() > 0) mq.delete(0);
    @(negedge clk);
    mem_read = 1'b0;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    addr      = a;
    wdata     = d;
    mem_write = 1'b1;
    if (a == ADDR_CTRL) begin
      m_irq_en = d[0];
      if (d[1]) m_ovr  = 1'b0;
      if (d[2]) m_ferr = 1'b0;
      if (d[3]) mq.delete();
    end
    @(negedge clk);
    mem_write = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  data;
    logic        stop;
    logic [31:0] st_before;
    logic [31:0] rxd;
    logic [31:0] st_after;
  } vec_t;

  vec_t        vecs[3];
  logic [31:0] got;
  int          cyc;
  logic [7:0]  rd;
  logic        rs;
  int          nrd;

  initial begin
    vecs[0] = '{data: 8'hA5, stop: 1'b1, st_before: 32'h11, rxd: 32'hA5, st_after: 32'h00};
    vecs[1] = '{data: 8'h3C, stop: 1'b0, st_before: 32'h08, rxd: 32'h00, st_after: 32'h08};
    vecs[2] = '{data: 8'h55, stop: 1'b1, st_before: 32'h11, rxd: 32'h55, st_after: 32'h00};

    reset     = 1'b1;
    uart_rx   = 1'b1;
    addr      = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    wdata     = '0;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    for (int a = 0; a < 16; a += 4) begin
      addr = 4'(a);
      #1 check($sformatf("reset_rdata_%0h", a), rdata, 32'h0);
    end
    check("reset_irq", {31'b0, rx_irq}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    idle(20);

    // Single frames: good byte, bad stop bit, good byte after a framing error
    for (int i = 0; i < 3; i++) begin
      send_frame(vecs[i].data, vecs[i].stop);
      idle(300);
      read_check($sformatf("v%0d_status", i), ADDR_STATUS, got);
      check($sformatf("v%0d_status_tbl", i), got, vecs[i].st_before);
      read_check($sformatf("v%0d_rxdata", i), ADDR_RXDATA, got);
      check($sformatf("v%0d_rxdata_tbl", i), got, vecs[i].rxd);
      read_check($sformatf("v%0d_status_after", i), ADDR_STATUS, got);
      check($sformatf("v%0d_status_after_tbl", i), got, vecs[i].st_after);
      bus_write(ADDR_CTRL, 32'h6);
      read_check($sformatf("v%0d_status_clr", i), ADDR_STATUS, got);
    end

    // Overrun: nine back-to-back frames with no reads
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1);
    idle(10);
    read_check("ovr_status", ADDR_STATUS, got);
    check("ovr_status_const", got, 32'h87);
    bus_write(ADDR_RXDATA, 32'hFFFF_FFFF);
    bus_write(ADDR_STATUS, 32'hFFFF_FFFF);
    read_check("ovr_status_after_ignored_writes", ADDR_STATUS, got);
    read_check("unmapped_read", 4'hC, got);
    for (int i = 1; i <= 8; i++) begin
      read_check($sformatf("ovr_rx%0d", i), ADDR_RXDATA, got);
      check($sformatf("ovr_rx%0d_const", i), got, 32'(i));
    end
    read_check("empty_rxdata", ADDR_RXDATA, got);
    read_check("empty_status", ADDR_STATUS, got);
    check("empty_status_const", got, 32'h04);
    bus_write(ADDR_CTRL, 32'h2);
    read_check("ovr_cleared", ADDR_STATUS, got);
    check("ovr_cleared_const", got, 32'h00);

    // Glitch rejection: a 100-clock low pulse must not start a frame
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (100) @(negedge clk);
    idle(600);
    read_check("glitch_status", ADDR_STATUS, got);
    check("glitch_status_const", got, 32'h00);

    // Interrupt timing: rise at the stop-sample push, fall at the popping read
    bus_write(ADDR_CTRL, 32'h1);
    read_check("ctrl_readback", ADDR_CTRL, got);
    check("irq_idle", {31'b0, rx_irq}, 32'h0);
    cyc = 0;
    fork
      send_frame(8'h7E, 1'b1);
      begin
        @(negedge clk);
        while (!rx_irq && cyc < 5000) begin
          @(negedge clk);
          cyc++;
        end
      end
    join
    checks++;
    if (cyc < 4106 || cyc > 4108) begin
      errors++;
      $display("FAIL irq_rise_cycle got=%0d want=4106..4108", cyc);
    end
    @(negedge clk);
    addr     = ADDR_RXDATA;
    mem_read = 1'b1;
    #1 check("irq_pop_rdata", rdata, 32'h7E);
    check("irq_before_pop", {31'b0, rx_irq}, 32'h1);
    @(posedge clk);
    #1 check("irq_after_pop", {31'b0, rx_irq}, 32'h0);
    mq.delete(0);
    @(negedge clk);
    mem_read = 1'b0;

    // Randomized frames against the model; the last one stays in the FIFO
    for (int f = 0; f < 3; f++) begin
      rd = 8'($urandom);
      rs = (f == 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
      send_frame(rd, rs);
      idle(300);
      read_check($sformatf("rnd%0d_status", f), ADDR_STATUS, got);
      check($sformatf("rnd%0d_irq", f), {31'b0, rx_irq}, model_irq());
      if (f < 2) begin
        nrd = $urandom_range(0, 2);
        for (int k = 0; k < nrd; k++) read_check($sformatf("rnd%0d_rx%0d", f, k), ADDR_RXDATA, got);
      end
      if (f == 1) begin
        bus_write(ADDR_CTRL, 32'h9);
        read_check("rnd_flush_status", ADDR_STATUS, got);
      end
    end

    // Reset mid-frame during bit 4 of 0xFF
    @(negedge clk);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    uart_rx = 1'b1;
    repeat (BIT_CLK / 2) @(negedge clk);
    reset = 1'b1;
    model_reset();
    for (int a = 0; a < 12; a += 4) begin
      addr = 4'(a);
      #1 check($sformatf("midreset_rdata_%0h", a), rdata, 32'h0);
    end
    check("midreset_irq", {31'b0, rx_irq}, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle(20);
    send_frame(8'h81, 1'b1);
    idle(20);
    read_check("post_reset_status", ADDR_STATUS, got);
    check("post_reset_status_const", got, 32'h11);
    read_check("post_reset_rxdata", ADDR_RXDATA, got);
    check("post_reset_rxdata_const", got, 32'h81);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
